// File: rtl/frogger_kbd_pkg.sv
// ---------------------------------------------------------------------------
// frogger_kbd_pkg : shared types and constants for the PS/2 keycode source
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package frogger_kbd_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } rx_state_e;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  localparam logic [15:0] KEY_LEFT  = 16'h0050;
  localparam logic [15:0] KEY_RIGHT = 16'h004F;
  localparam logic [15:0] KEY_UP    = 16'h0052;
  localparam logic [15:0] KEY_DOWN  = 16'h0051;
  localparam logic [15:0] KEY_FROG1 = 16'h0059;
  localparam logic [15:0] KEY_FROG2 = 16'h005A;
  localparam logic [15:0] KEY_FROG3 = 16'h005B;

  typedef struct packed {
    logic        hit;
    logic [15:0] usage;
  } key_map_t;

  function automatic key_map_t ps2_map(input logic ext, input logic [7:0] code);
    key_map_t m;
    m.hit   = 1'b1;
    m.usage = 16'h0000;
    case ({ext, code})
      {1'b1, 8'h6B}: m.usage = KEY_LEFT;
      {1'b1, 8'h74}: m.usage = KEY_RIGHT;
      {1'b1, 8'h75}: m.usage = KEY_UP;
      {1'b1, 8'h72}: m.usage = KEY_DOWN;
      {1'b0, 8'h69}: m.usage = KEY_FROG1;
      {1'b0, 8'h72}: m.usage = KEY_FROG2;
      {1'b0, 8'h7A}: m.usage = KEY_FROG3;
      default:       m.hit   = 1'b0;
    endcase
    return m;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ps2_frame_rx.sv
// ---------------------------------------------------------------------------
// ps2_frame_rx : PS/2 synchroniser, clock glitch filter and 11-bit frame FSM.
// Optional frame timeout enabled by PS2_TIMEOUT_EN.  Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ps2_frame_rx
  import frogger_kbd_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       frame_error
);

  localparam int FLT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [FLT_W-1:0] FLT_LAST = FLT_W'(FILTER_LEN - 1);

  logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
  logic [SYNC_STAGES-1:0] dat_sync_q, dat_sync_d;
  logic [FLT_W-1:0]       flt_cnt_q, flt_cnt_d;
  logic                   filt_q, filt_d;
  logic                   filt_prev_q, filt_prev_d;
  rx_state_e              state_q, state_d;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic [7:0]             shift_q, shift_d;
  logic                   parity_q, parity_d;
  logic                   strike;
  logic                   dat_s;

`ifdef PS2_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;
`else
  logic unused_tmo_cfg;
  assign unused_tmo_cfg = (TIMEOUT_CYCLES > 0);
`endif

  assign strike  = filt_prev_q & ~filt_q;
  assign dat_s   = dat_sync_q[SYNC_STAGES-1];
  assign rx_byte = shift_q;

  always_comb begin
    clk_sync_d  = {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
    dat_sync_d  = {dat_sync_q[SYNC_STAGES-2:0], ps2_dat};
    flt_cnt_d   = '0;
    filt_d      = filt_q;
    filt_prev_d = filt_q;
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    parity_d    = parity_q;
    byte_valid  = 1'b0;
    frame_error = 1'b0;

    // A level change is accepted only after FILTER_LEN consecutive samples.
    if (clk_sync_q[SYNC_STAGES-1] != filt_q) begin
      if (flt_cnt_q == FLT_LAST) begin
        filt_d = clk_sync_q[SYNC_STAGES-1];
      end else begin
        flt_cnt_d = flt_cnt_q + 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        if (strike && !dat_s) begin
          state_d   = DATA;
          bit_cnt_d = 3'd0;
        end
      end
      DATA: begin
        if (strike) begin
          shift_d   = {dat_s, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = PARITY;
        end
      end
      PARITY: begin
        if (strike) begin
          parity_d = dat_s;
          state_d  = STOP;
        end
      end
      STOP: begin
        if (strike) begin
          state_d = IDLE;
          if ((^{shift_q, parity_q}) && dat_s) byte_valid  = 1'b1;
          else                                 frame_error = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

`ifdef PS2_TIMEOUT_EN
    tmo_d = tmo_q + 1'b1;
    if (strike || state_q == IDLE) begin
      tmo_d = '0;
    end else if (tmo_q == TMO_LAST) begin
      tmo_d       = '0;
      state_d     = IDLE;
      frame_error = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync_q  <= '1;
      dat_sync_q  <= '1;
      flt_cnt_q   <= '0;
      filt_q      <= 1'b1;
      filt_prev_q <= 1'b1;
      state_q     <= IDLE;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 8'h00;
      parity_q    <= 1'b0;
`ifdef PS2_TIMEOUT_EN
      tmo_q       <= '0;
`endif
    end else begin
      clk_sync_q  <= clk_sync_d;
      dat_sync_q  <= dat_sync_d;
      flt_cnt_q   <= flt_cnt_d;
      filt_q      <= filt_d;
      filt_prev_q <= filt_prev_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      parity_q    <= parity_d;
`ifdef PS2_TIMEOUT_EN
      tmo_q       <= tmo_d;
`endif
    end
  end

endmodule

`default_nettype wire

// File: rtl/ps2_keycode_source.sv
// ---------------------------------------------------------------------------
// ps2_keycode_source : PS/2 set-2 keyboard to 16-bit HID usage keycode.
// PS2_TIMEOUT_EN enables the partial-frame timeout.  Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ps2_keycode_source
  import frogger_kbd_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        PS2_CLK,
  input  logic        PS2_DAT,
  output logic [15:0] keycode,
  output logic        key_event,
  output logic        frame_error,
  output logic [7:0]  scan_code
);

  logic [7:0]  rx_byte;
  logic        rx_valid;
  logic        rx_err;
  logic        ext_q, ext_d;
  logic        brk_q, brk_d;
  logic [15:0] keycode_q, keycode_d;
  logic [7:0]  scan_code_q, scan_code_d;
  logic        key_event_q, key_event_d;
  logic        frame_error_q, frame_error_d;
  key_map_t    map;

  ps2_frame_rx #(
    .SYNC_STAGES    (SYNC_STAGES),
    .FILTER_LEN     (FILTER_LEN),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_rx (
    .clk         (Clk),
    .rst_n       (Reset_n),
    .ps2_clk     (PS2_CLK),
    .ps2_dat     (PS2_DAT),
    .rx_byte     (rx_byte),
    .byte_valid  (rx_valid),
    .frame_error (rx_err)
  );

  assign map = ps2_map(ext_q, rx_byte);

  always_comb begin
    ext_d         = ext_q;
    brk_d         = brk_q;
    keycode_d     = keycode_q;
    scan_code_d   = scan_code_q;
    frame_error_d = rx_err;

    if (rx_err) begin
      ext_d = 1'b0;
      brk_d = 1'b0;
    end else if (rx_valid) begin
      scan_code_d = rx_byte;
      if (rx_byte == PS2_EXT) begin
        ext_d = 1'b1;
      end else if (rx_byte == PS2_BRK) begin
        brk_d = 1'b1;
      end else begin
        // Only releasing the currently held key clears it.
        if (map.hit) begin
          if (!brk_q)                      keycode_d = map.usage;
          else if (map.usage == keycode_q) keycode_d = 16'h0000;
        end
        ext_d = 1'b0;
        brk_d = 1'b0;
      end
    end

    key_event_d = (keycode_d != keycode_q);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      ext_q         <= 1'b0;
      brk_q         <= 1'b0;
      keycode_q     <= 16'h0000;
      scan_code_q   <= 8'h00;
      key_event_q   <= 1'b0;
      frame_error_q <= 1'b0;
    end else begin
      ext_q         <= ext_d;
      brk_q         <= brk_d;
      keycode_q     <= keycode_d;
      scan_code_q   <= scan_code_d;
      key_event_q   <= key_event_d;
      frame_error_q <= frame_error_d;
    end
  end

  assign keycode     = keycode_q;
  assign scan_code   = scan_code_q;
  assign key_event   = key_event_q;
  assign frame_error = frame_error_q;

endmodule

`default_nettype wire
